serial_sub4: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_sub_bit.sv | 16 +
 rtl/serial_sub4.sv | 112 +++++++++++
 tb/tb_serial_sub4.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for serial_sub4 (optional V output via SERIAL_SUB_OVF_EN)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter must be able to hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// rtl/full_sub_bit.sv - combinational one-bit full subtractor cell
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bn
);

  // Difference and borrow-out of a - b - c.
  always_comb begin
    d  = a ^ b ^ c;
    bn = (~a & b) | (~(a ^ b) & c);
  end

endmodule

// File: rtl/serial_sub4.sv
// rtl/serial_sub4.sv - bit-serial subtractor D = A - B - Bi, LSB first; SERIAL_SUB_OVF_EN adds signed overflow output V
module serial_sub4
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  // r_ra doubles as the result shift register: each step frees its MSB,
  // which receives the new difference bit.
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bn;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

  full_sub_bit u_bit (
    .a  (r_ra[0]),
    .b  (r_rb[0]),
    .c  (r_br),
    .d  (w_d),
    .bn (w_bn)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: start only matters in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, one bit step per SHIFT cycle, result load on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra  <= '0;
      r_rb  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      D     <= '0;
      Bo    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      V     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ra  <= A;
            r_rb  <= B;
            r_br  <= Bi;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_ra  <= {w_d, r_ra[WIDTH-1:1]};
          r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
          r_br  <= w_bn;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            D  <= {w_d, r_ra[WIDTH-1:1]};
            Bo <= w_bn;
`ifdef SERIAL_SUB_OVF_EN
            // r_br here is the borrow into the MSB step.
            V  <= r_br ^ w_bn;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// tb/tb_serial_sub4.sv - self-checking bench for serial_sub4 (V checks enabled by SERIAL_SUB_OVF_EN)
module tb_serial_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bi;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bo;
`ifdef SERIAL_SUB_OVF_EN
  logic         V;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bo    (Bo)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .V     (V)
`endif
  );

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int a, input int b, input int bi,
                                output logic [W-1:0] d, output logic bo, output logic v);
    int diff, sa, sb, sd;
    diff = a - b - bi;
    d    = W'(diff);
    bo   = (diff < 0);
    sa   = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
    sb   = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
    sd   = sa - sb - bi;
    v    = (sd < -(2 ** (W - 1))) || (sd > 2 ** (W - 1) - 1);
  endfunction

  function automatic logic cur_v();
`ifdef SERIAL_SUB_OVF_EN
    return V;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation and observe it; the caller does the comparisons.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic v,
                       output int lat, output int busy_n, output logic d_held,
                       output logic idle_after);
    logic [W-1:0] d_prev;
    @(negedge clk);
    A = a; B = b; Bi = bi; start = 1'b1;
    d_prev = D;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bi = 1'($urandom);
    lat    = -1;
    busy_n = busy ? 1 : 0;
    d_held = 1'b1;
    for (int k = 1; k <= 3 * W + 10; k++) begin
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      if (D !== d_prev) d_held = 1'b0;
    end
    d  = D;
    bo = Bo;
    v  = cur_v();
    @(posedge clk); #1;
    idle_after = !busy && !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
    #12;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_vec++; if (D !== '0) begin n_err++; $display("FAIL reset_D: got %0d expected 0", D); end
    n_vec++; if (Bo !== 1'b0) begin n_err++; $display("FAIL reset_Bo: got %0b expected 0", Bo); end
`ifdef SERIAL_SUB_OVF_EN
    n_vec++; if (V !== 1'b0) begin n_err++; $display("FAIL reset_V: got %0b expected 0", V); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int ta [6] = '{9, 3, 0, 8, 7, 5};
    int tb [6] = '{3, 9, 0, 1, 15, 2};
    int tc [6] = '{0, 0, 1, 0, 0, 0};
    logic [W-1:0] d, ed;
    logic bo, v, ebo, ev, held, idle;
    int lat, bn;
    for (int i = 0; i < 6; i++) begin
      do_op(W'(ta[i]), W'(tb[i]), 1'(tc[i]), d, bo, v, lat, bn, held, idle);
      model(ta[i], tb[i], tc[i], ed, ebo, ev);
      n_vec++; if (d !== ed) begin n_err++; $display("FAIL dir_D[%0d]: got %0d expected %0d", i, d, ed); end
      n_vec++; if (bo !== ebo) begin n_err++; $display("FAIL dir_Bo[%0d]: got %0b expected %0b", i, bo, ebo); end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++; if (v !== ev) begin n_err++; $display("FAIL dir_V[%0d]: got %0b expected %0b", i, v, ev); end
`endif
      n_vec++; if (lat !== W) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, W); end
      n_vec++; if (bn !== W + 1) begin n_err++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bn, W + 1); end
      n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL dir_D_held[%0d]: got %0b expected 1", i, held); end
      n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL dir_idle_after[%0d]: got %0b expected 1", i, idle); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d, ed;
    logic bi, bo, v, ebo, ev, held, idle;
    int lat, bn;
    for (int i = 0; i < 30; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      bi = 1'($urandom);
      do_op(a, b, bi, d, bo, v, lat, bn, held, idle);
      model(int'(a), int'(b), int'(bi), ed, ebo, ev);
      n_vec++; if (d !== ed) begin n_err++; $display("FAIL rnd_D a=%0d b=%0d bi=%0b: got %0d expected %0d", a, b, bi, d, ed); end
      n_vec++; if (bo !== ebo) begin n_err++; $display("FAIL rnd_Bo a=%0d b=%0d bi=%0b: got %0b expected %0b", a, b, bi, bo, ebo); end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++; if (v !== ev) begin n_err++; $display("FAIL rnd_V a=%0d b=%0d bi=%0b: got %0b expected %0b", a, b, bi, v, ev); end
`endif
      n_vec++; if (lat !== W) begin n_err++; $display("FAIL rnd_latency: got %0d expected %0d", lat, W); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [W-1:0] d = '0;
    logic bo = 1'b1;
    @(negedge clk);
    A = 12; B = 4; Bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    A = 1; B = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) begin ndone++; d = D; bo = Bo; end
    for (int k = 0; k < 2 * W + 6; k++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; d = D; bo = Bo; end
    end
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d expected 1", ndone); end
    n_vec++; if (d !== W'(8)) begin n_err++; $display("FAIL ign_D: got %0d expected 8", d); end
    n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL ign_Bo: got %0b expected 0", bo); end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    logic [W-1:0] d;
    logic bo, v, held, idle;
    int lat, bn;
    @(negedge clk);
    A = 15; B = 1; Bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %0b expected 0", done); end
    n_vec++; if (D !== '0) begin n_err++; $display("FAIL abort_D: got %0d expected 0", D); end
    n_vec++; if (Bo !== 1'b0) begin n_err++; $display("FAIL abort_Bo: got %0b expected 0", Bo); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * W + 4; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    do_op(6, 6, 1'b0, d, bo, v, lat, bn, held, idle);
    n_vec++; if (d !== '0) begin n_err++; $display("FAIL abort_fresh_D: got %0d expected 0", d); end
    n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL abort_fresh_Bo: got %0b expected 0", bo); end
    n_vec++; if (lat !== W) begin n_err++; $display("FAIL abort_fresh_latency: got %0d expected %0d", lat, W); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, ed;
    logic ebo, ev, exp_done, exp_busy;
    a = W'($urandom);
    b = W'($urandom);
    model(int'(a), int'(b), 0, ed, ebo, ev);
    @(negedge clk);
    A = a; B = b; Bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2 * (W + 2); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      exp_done = ((i % (W + 2)) == W);
      exp_busy = ((i % (W + 2)) != W + 1);
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL b2b_done[%0d]: got %0b expected %0b", i, done, exp_done); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL b2b_busy[%0d]: got %0b expected %0b", i, busy, exp_busy); end
      if (exp_done) begin
        n_vec++; if (D !== ed) begin n_err++; $display("FAIL b2b_D[%0d]: got %0d expected %0d", i, D, ed); end
        n_vec++; if (Bo !== ebo) begin n_err++; $display("FAIL b2b_Bo[%0d]: got %0b expected %0b", i, Bo, ebo); end
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
